// File: rtl/pwm_pkg.sv
// Shared types and defaults for the centre-aligned PWM generator.
package pwm_pkg;

    typedef enum logic [1:0] {
        LO_ON,
        HI_ON,
        DEAD
    } pwm_state_t;

    localparam int PWM_WIDTH_DEF = 8;
    localparam int DT_W_DEF      = 4;

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time inserter: turns the raw compare result into complementary gate drives
// that are never both high and are both low for max(dt_cycles,1) clocks per transition.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            raw_q,
    input  logic [DT_W-1:0] dt_cycles,
    output logic            pwm_hi,
    output logic            pwm_lo
);

    localparam logic [DT_W-1:0] CNT_ONE = DT_W'(1);
    localparam logic [DT_W-1:0] CNT_MAX = '1;

    pwm_state_t      state_q, state_d;
    logic            target_hi_q, target_hi_d;
    logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;
    logic            pwm_hi_d, pwm_lo_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= DEAD;
            target_hi_q <= 1'b0;
            dt_cnt_q    <= CNT_ONE;
            pwm_hi      <= 1'b0;
            pwm_lo      <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_hi_q <= target_hi_d;
            dt_cnt_q    <= dt_cnt_d;
            pwm_hi      <= pwm_hi_d;
            pwm_lo      <= pwm_lo_d;
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d     = state_q;
        target_hi_d = target_hi_q;
        dt_cnt_d    = dt_cnt_q;
        case (state_q)
            HI_ON: if (!raw_q) begin
                state_d     = DEAD;
                target_hi_d = 1'b0;
                dt_cnt_d    = CNT_ONE;
            end
            LO_ON: if (raw_q) begin
                state_d     = DEAD;
                target_hi_d = 1'b1;
                dt_cnt_d    = CNT_ONE;
            end
            DEAD: begin
                // A flip of the raw request during dead time restarts the whole gap.
                if (raw_q != target_hi_q) begin
                    target_hi_d = raw_q;
                    dt_cnt_d    = CNT_ONE;
                end else if (dt_cnt_q >= dt_cycles) begin
                    state_d = target_hi_q ? HI_ON : LO_ON;
                end else if (dt_cnt_q != CNT_MAX) begin
                    dt_cnt_d = dt_cnt_q + CNT_ONE;
                end
            end
            default: state_d = DEAD;
        endcase
    end

    always_comb begin
        pwm_hi_d = (state_d == HI_ON);
        pwm_lo_d = (state_d == LO_ON);
    end

endmodule

// File: rtl/center_pwm_gen.sv
// Centre-aligned complementary PWM from an up/down triangle count, with a
// double-buffered compare value that is applied only at the triangle bottom.
module center_pwm_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DEF,
    parameter int DT_W  = DT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count,
    input  logic             up_down,
    input  logic [WIDTH-1:0] cmp_data,
    input  logic             cmp_valid,
    output logic             cmp_ready,
    input  logic [DT_W-1:0]  dt_cycles,
    output logic             pwm_hi,
    output logic             pwm_lo,
    output logic             period_start,
    output logic [WIDTH-1:0] cmp_active
);

    logic [WIDTH-1:0] pend;
    logic             pend_v;
    logic             prev_zero;
    logic             raw_q;
    logic             dir_q;
    logic             count_zero;
    logic             bot;
    logic             accept;

    assign count_zero = (count == '0);
    assign bot        = count_zero && !prev_zero;
    assign cmp_ready  = !pend_v;
    assign accept     = cmp_valid && cmp_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmp_active   <= '0;
            pend         <= '0;
            pend_v       <= 1'b0;
            prev_zero    <= 1'b0;
            raw_q        <= 1'b0;
            period_start <= 1'b0;
            dir_q        <= 1'b0;
        end else begin
            prev_zero    <= count_zero;
            period_start <= bot;
            dir_q        <= up_down;
            // NOTE: non-blocking, so this compares against cmp_active as it was before this edge.
            raw_q        <= (count < cmp_active);
            // An accept on the bottom cycle only fills the shadow; it applies next period.
            if (bot && pend_v) begin
                cmp_active <= pend;
                pend_v     <= 1'b0;
            end else if (accept) begin
                pend   <= cmp_data;
                pend_v <= 1'b1;
            end
        end
    end

    pwm_deadtime #(
        .DT_W(DT_W)
    ) u_deadtime (
        .clk       (clk),
        .reset     (reset),
        .raw_q     (raw_q),
        .dt_cycles (dt_cycles),
        .pwm_hi    (pwm_hi),
        .pwm_lo    (pwm_lo)
    );

endmodule
